// File: rtl/da_sample_feeder_if.sv
// Purpose : producer-side sample stream for da_sample_feeder (valid/ready/data).
// Latency : n/a (signal bundle only).
// Backpressure: s_ready low stalls the producer; a beat transfers on s_valid & s_ready.
//
// Ports (via modports):
//   master - producer: drives s_valid, s_data; observes s_ready
//   slave  - feeder:   observes s_valid, s_data; drives s_ready
interface da_sample_feeder_if #(
   parameter int WORD_WIDTH = 16
) ();

   logic                  s_valid;
   logic [WORD_WIDTH-1:0] s_data;
   logic                  s_ready;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );

endinterface : da_sample_feeder_if

// File: rtl/da_sample_feeder.sv
// Purpose : buffers producer samples and presents each one on x for exactly one
//           filter frame of FRAME_LEN cycles with en high (bit-serial DA FIR front end).
// Latency : push into an empty, idle/stalled feeder -> x/en/frame_start 2 cycles later;
//           while running, the next sample follows the last frame cycle with no gap.
// Backpressure: s_ready = (registered level < FIFO_DEPTH); no pass-through when full.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   flush        synchronous clear of FIFO and frame state (wins over push/pop)
//   s            sample stream (slave modport: s_valid, s_data in; s_ready out)
//   x            sample held for the filter for one whole frame
//   en           filter enable, high for FRAME_LEN cycles per sample
//   frame_start  pulse in the first cycle of each frame
//   level        samples buffered, not counting the one on x
//   underrun     pulse in the last cycle of a frame when no sample is waiting
module da_sample_feeder #(
   parameter int WORD_WIDTH = 16,
   parameter int FRAME_LEN  = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   da_sample_feeder_if.slave             s,
   output logic [WORD_WIDTH-1:0]         x,
   output logic                          en,
   output logic                          frame_start,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          underrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(FRAME_LEN);

   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(FRAME_LEN - 2);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;

   logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [LW-1:0]         level_nxt;
   logic [WORD_WIDTH-1:0] head;

   logic                  s_ready_int;
   logic                  push;
   logic                  load;
   logic                  frame_end;

   // Ready depends on the registered occupancy only, so a full FIFO refuses a
   // sample even in a cycle where the FSM is popping.
   assign s_ready_int = (level < LVL_FULL);
   assign s.s_ready   = s_ready_int;

   assign head = mem[rd_ptr];

   always_comb begin
      frame_end = (state == RUN) && (cnt == CNT_LAST);
      push      = s.s_valid && s_ready_int && !flush;
      // A pop is the same event as loading a new frame onto x.
      load      = !flush && (level != '0) &&
                  ((state == IDLE) || (state == STALL) || frame_end);

      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else begin
         unique case ({push, load})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
         endcase
      end
   end

   // Sample storage carries no reset: an entry is only read after it is written,
   // and occupancy/pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s.s_data;
      end
   end

   // Circular buffer bookkeeping; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         level <= level_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Frame sequencer with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         x           <= '0;
         en          <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            x     <= '0;
            en    <= 1'b0;
         end else begin
            // underrun must be visible during the last frame cycle itself, so it
            // is decided one cycle early. No pop can happen mid-frame, so the
            // occupancy seen in the last cycle is exactly level_nxt here.
            if ((state == RUN) && (cnt == CNT_PRE) && (level_nxt == '0)) begin
               underrun <= 1'b1;
            end

            unique case (state)
               IDLE, STALL: begin
                  if (load) begin
                     x           <= head;
                     en          <= 1'b1;
                     frame_start <= 1'b1;
                     cnt         <= '0;
                     state       <= RUN;
                  end
               end

               RUN: begin
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     if (load) begin
                        // Back-to-back frame: en stays high, x steps.
                        x           <= head;
                        frame_start <= 1'b1;
                     end else begin
                        // Hold the last sample on x while waiting for data.
                        en    <= 1'b0;
                        state <= STALL;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end

               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  x     <= '0;
                  en    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : da_sample_feeder

// File: doc/da_sample_feeder.md
Name: da_sample_feeder

Overview:
- Upstream input stage for the distributed-arithmetic FIR top.
- Accepts parallel samples over a valid/ready handshake and buffers them in a small FIFO.
- Presents each sample to the filter's x input, held stable for exactly one filter frame of FRAME_LEN cycles, with en asserted for the whole frame.
- Shields the bit-serial filter from bursty or irregular producers.

Parameters:
WORD_WIDTH, 16, sample width; matches filter x width
FRAME_LEN, 17, clock cycles the filter needs per sample (x held, en high); must be >= 2
FIFO_DEPTH, 4, sample buffer entries; power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of FIFO and frame state
s_valid  input  1  producer has a sample on s_data
s_data  input  WORD_WIDTH  sample from producer
s_ready  output  1  feeder can accept a sample this cycle
x  output  WORD_WIDTH  sample driven to filter x
en  output  1  filter enable; high during an active frame
frame_start  output  1  one-cycle pulse in the first cycle of each frame
level  output  $clog2(FIFO_DEPTH)+1  samples currently buffered (excludes sample on x)
underrun  output  1  one-cycle pulse when a frame ends with FIFO empty

Behaviour:
- Reset (rst low, async): FIFO empty, level=0, state IDLE, x=0, en=0, frame_start=0, underrun=0.
- s_ready is high when level < FIFO_DEPTH. It is driven from registered level only; there is no same-cycle pass-through when full.
- Push occurs on s_valid & s_ready. Pop occurs when the FSM loads a new frame.
- Simultaneous push and pop leaves level unchanged.
- FIFO is circular. Read and write pointers wrap modulo FIFO_DEPTH, with level tracking occupancy.
- Frame counter cnt runs 0..FRAME_LEN-1.
- FSM states: IDLE, RUN, STALL. All outputs are registered.
  - IDLE: en=0, x=0. If level>0: pop, x<=head, en<=1, frame_start<=1, cnt<=0, go to RUN.
  - RUN: en=1, x held constant, cnt increments each cycle.
    - At cnt==FRAME_LEN-1 with level>0: pop, load new x, cnt<=0, frame_start pulse next cycle, stay in RUN. This gives back-to-back frames with no gap.
    - At cnt==FRAME_LEN-1 with level==0: en<=0, x held at last value, underrun pulses for one cycle, go to STALL.
  - STALL: en=0, x held. If level>0: identical to the IDLE load action, go to RUN.
- Latency:
  - A sample pushed in cycle c into an empty feeder in IDLE/STALL appears on x with en=1 and frame_start=1 in cycle c+2.
  - In RUN, the next sample appears in the cycle after the cnt==FRAME_LEN-1 cycle.
- en is high for exactly FRAME_LEN consecutive cycles per sample. x never changes mid-frame.
- flush (synchronous, highest priority over push/pop in that cycle):
  - Empties the FIFO (level=0, pointers=0).
  - Sets state IDLE, x=0, en=0, cnt=0.
  - Suppresses underrun and frame_start.
  - A sample offered while flush is high is dropped, and s_ready stays as computed from level.
- Reset mid-frame: all outputs return to reset values immediately. No partial frame resumes after rst releases.
- Full FIFO with a pop in the same cycle: s_ready stays low that cycle and a producer push is not accepted.
- level never exceeds FIFO_DEPTH and never underflows. The sample currently on x is not counted.

Test Plan:
1. Reset then push 0x1234 in cycle 0 -> cycle 2: x=0x1234, en=1, frame_start=1; en stays high cycles 2..18 (FRAME_LEN=17); cycle 18 underrun=1; cycle 19 en=0, x=0x1234.
2. Push 0x0001..0x0005 back-to-back -> s_ready low once level=4; frames are contiguous, x steps 1,2,3,4,5 every 17 cycles, frame_start pulses every 17 cycles, no en gap.
3. Push and pop in the same cycle at level=2 -> level stays 2; the accepted sample emerges in FIFO order.
4. Assert flush mid-frame with level=3 -> next cycle en=0, x=0, level=0, s_ready=1, no underrun pulse; a sample pushed afterwards follows the 2-cycle latency from IDLE.
5. Drop rst low mid-frame (cnt=8, level=2) -> outputs zero asynchronously; after release, en stays low until a new push.
6. STALL recovery: after an underrun, push 0xBEEF -> 2 cycles later x=0xBEEF, en=1, frame_start=1, full 17-cycle frame follows.
